// File: rtl/vppm_pwm_pkg.sv
// Shared types for the multi-channel PWM/VPPM generator: default value width,
// channel mode and the per-channel configuration record.
package vppm_pwm_pkg;

  localparam int PWM_W = 26;

  typedef enum logic {
    MODE_PWM  = 1'b0,
    MODE_VPPM = 1'b1
  } mode_e;

  typedef struct packed {
    logic [PWM_W-1:0] duty;
    logic [PWM_W-1:0] delay;
    mode_e            mode;
  } ch_cfg_t;

endpackage

// File: rtl/vppm_pwm_channel.sv
// One output channel: pending/shadow config, sampled VPPM symbol bit,
// delay clamp and the registered compare against the shared counter.
module vppm_pwm_channel
  import vppm_pwm_pkg::*;
#(
  parameter int W = PWM_W
) (
  input  logic         clk_50,
  input  logic         rst_n,
  input  logic         en,
  input  logic         wr,
  input  logic         commit,
  input  ch_cfg_t      cfg_in,
  input  logic         sym_in,
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] p_act,
  output logic         pending,
  output logic         pwm_out
);

  ch_cfg_t      pend_q, pend_d, shadow_q, shadow_d;
  logic         pending_q, pending_d;
  logic         sym_q, sym_d;
  logic         pwm_q, pwm_d;
  logic [W-1:0] duty, delay, dly_c, pos;
  logic         hi;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      sym_q     <= 1'b0;
      pwm_q     <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      sym_q     <= sym_d;
      pwm_q     <= pwm_d;
    end
  end

  // A write landing on the commit cycle bypasses the pending slot entirely.
  always_comb begin
    pend_d    = pend_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    sym_d     = sym_q;
    if (commit) begin
      pending_d = 1'b0;
      sym_d     = sym_in;
      if (wr) shadow_d = cfg_in;
      else if (pending_q) shadow_d = pend_q;
    end else if (wr) begin
      pend_d    = cfg_in;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    duty  = W'(shadow_q.duty);
    delay = W'(shadow_q.delay);
    dly_c = (delay >= p_act) ? p_act - W'(1) : delay;
    // Modular subtraction: result is always < p_act, so W bits suffice.
    pos   = cnt - dly_c + ((cnt < dly_c) ? p_act : '0);
    if (duty == '0) hi = 1'b0;
    else if (duty >= p_act) hi = 1'b1;
    else if (shadow_q.mode == MODE_VPPM) hi = sym_q ? (cnt >= p_act - duty) : (cnt < duty);
    else hi = (pos < duty);
    pwm_d = en & hi;
  end

  assign pending = pending_q;
  assign pwm_out = pwm_q;

endmodule

// File: rtl/vppm_pwm_gen.sv
// Multi-channel PWM/VPPM generator: shared period counter and period shadow,
// config write decode and per-channel instances committing at period wrap.
module vppm_pwm_gen
  import vppm_pwm_pkg::*;
#(
  parameter int  CH         = 4,
  parameter int  W          = PWM_W,
  parameter int  DEF_PERIOD = 5000,
  localparam int CHW        = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk_50,
  input  logic           rst_n,
  input  logic           en,
  input  logic [W-1:0]   period,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [W-1:0]   cfg_duty,
  input  logic [W-1:0]   cfg_delay,
  input  logic           cfg_mode,
  input  logic [CH-1:0]  sym_bit,
  output logic [CH-1:0]  pwm_out,
  output logic           period_tick
);

  logic [W-1:0]  cnt_q, cnt_d, per_q, per_d, p_act;
  logic          tick_q, tick_d;
  logic          wrap, accept;
  logic [CH-1:0] pending, wr_vec;
  ch_cfg_t       cfg_in;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      per_q  <= W'(DEF_PERIOD);
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      tick_q <= tick_d;
    end
  end

  // While disabled every cycle is a commit point, so config flows straight through.
  assign p_act = (per_q < W'(2)) ? W'(2) : per_q;
  assign wrap  = !en || (cnt_q == p_act - W'(1));

  always_comb begin
    cnt_d  = (!en || wrap) ? '0 : cnt_q + W'(1);
    per_d  = wrap ? period : per_q;
    tick_d = en && (cnt_q == '0);
  end

  // Handshake: a write transfers on a cycle with cfg_valid && cfg_ready; the
  // target channel stays not-ready until its pending write commits at wrap.
  always_comb begin
    cfg_ready = 1'b0;
    if (int'(cfg_ch) < CH) cfg_ready = !pending[cfg_ch];
  end

  assign accept = cfg_valid && cfg_ready;

  always_comb begin
    wr_vec = '0;
    for (int i = 0; i < CH; i++) wr_vec[i] = accept && (cfg_ch == CHW'(i));
  end

  always_comb begin
    cfg_in       = '0;
    cfg_in.duty  = PWM_W'(cfg_duty);
    cfg_in.delay = PWM_W'(cfg_delay);
    cfg_in.mode  = mode_e'(cfg_mode);
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    vppm_pwm_channel #(.W(W)) u_ch (
      .clk_50  (clk_50),
      .rst_n   (rst_n),
      .en      (en),
      .wr      (wr_vec[i]),
      .commit  (wrap),
      .cfg_in  (cfg_in),
      .sym_in  (sym_bit[i]),
      .cnt     (cnt_q),
      .p_act   (p_act),
      .pending (pending[i]),
      .pwm_out (pwm_out[i])
    );
  end

  assign period_tick = tick_q;

endmodule

// File: tb/tb_vppm_pwm_gen.sv
// Directed bench for vppm_pwm_gen: per-position pattern checks of all channels
// plus handshake, period, enable and reset scenarios.
module tb_vppm_pwm_gen;

  localparam int CH = 4;
  localparam int W  = 26;

  logic          clk_50 = 1'b0;
  logic          rst_n;
  logic          en;
  logic [W-1:0]  period;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_ch;
  logic [W-1:0]  cfg_duty;
  logic [W-1:0]  cfg_delay;
  logic          cfg_mode;
  logic [CH-1:0] sym_bit;
  logic [CH-1:0] pwm_out;
  logic          period_tick;

  int checks   = 0;
  int failures = 0;

  vppm_pwm_gen #(.CH(CH), .W(W), .DEF_PERIOD(5000)) dut (
    .clk_50      (clk_50),
    .rst_n       (rst_n),
    .en          (en),
    .period      (period),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_duty    (cfg_duty),
    .cfg_delay   (cfg_delay),
    .cfg_mode    (cfg_mode),
    .sym_bit     (sym_bit),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  always #5 clk_50 = ~clk_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int ch, input int duty, input int delay, input logic mode);
    cfg_ch    = 2'(ch);
    cfg_duty  = W'(duty);
    cfg_delay = W'(delay);
    cfg_mode  = mode;
    cfg_valid = 1'b1;
    #1;
  endtask

  // Checks n output cycles starting at position 'start'; called at a negedge.
  task automatic check_cycles(input int p, input int start, input int n,
                              input logic [15:0] p0, input logic [15:0] p1,
                              input logic [15:0] p2, input logic [15:0] p3);
    int pos;
    for (int k = 0; k < n; k++) begin
      pos = (start + k) % p;
      chk($sformatf("tick_p%0d_pos%0d", p, pos), 32'(period_tick), 32'(pos == 0));
      chk($sformatf("pwm_p%0d_pos%0d", p, pos), 32'(pwm_out),
          {28'd0, p3[pos], p2[pos], p1[pos], p0[pos]});
      @(negedge clk_50);
      cfg_valid = 1'b0;
    end
  endtask

  task automatic check_period(input int p, input logic [15:0] p0, input logic [15:0] p1,
                              input logic [15:0] p2, input logic [15:0] p3);
    check_cycles(p, 0, p, p0, p1, p2, p3);
  endtask

  task automatic tick_interval(input string tag, input int exp);
    int n;
    n = 0;
    for (int k = 1; k <= 6000; k++) begin
      @(negedge clk_50);
      if (period_tick) begin
        n = k;
        break;
      end
    end
    chk(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    period    = W'(10);
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_duty  = '0;
    cfg_delay = '0;
    cfg_mode  = 1'b0;
    sym_bit   = '0;

    // Reset state
    repeat (3) @(negedge clk_50);
    chk("rst_pwm", 32'(pwm_out), 32'h0);
    chk("rst_tick", 32'(period_tick), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h1);
    rst_n = 1'b1;
    @(negedge clk_50);

    // PWM basic: config loaded while disabled
    set_cfg(0, 3, 0, 1'b0);
    @(negedge clk_50);
    cfg_valid = 1'b0;
    en = 1'b1;
    @(negedge clk_50);
    check_period(10, 16'h0007, 16'h0, 16'h0, 16'h0);
    check_period(10, 16'h0007, 16'h0, 16'h0, 16'h0);

    // Phase wrap, then delay clamp 15 -> 9
    set_cfg(0, 3, 8, 1'b0);
    check_period(10, 16'h0007, 16'h0, 16'h0, 16'h0);
    check_period(10, 16'h0301, 16'h0, 16'h0, 16'h0);
    set_cfg(0, 3, 15, 1'b0);
    check_period(10, 16'h0301, 16'h0, 16'h0, 16'h0);
    check_period(10, 16'h0203, 16'h0, 16'h0, 16'h0);

    // VPPM: bit 0 then bit 1; the bit raised mid-period waits for wrap
    set_cfg(0, 4, 0, 1'b1);
    check_period(10, 16'h0203, 16'h0, 16'h0, 16'h0);
    sym_bit = 4'b0001;
    check_period(10, 16'h000F, 16'h0, 16'h0, 16'h0);
    check_period(10, 16'h03C0, 16'h0, 16'h0, 16'h0);

    // Handshake: ch1 twice in one period, ch2 meanwhile
    set_cfg(1, 2, 0, 1'b0);
    chk("hs_ready_ch1_first", 32'(cfg_ready), 32'h1);
    @(negedge clk_50);
    chk("hs_ready_ch1_pend", 32'(cfg_ready), 32'h0);
    set_cfg(1, 5, 0, 1'b0);
    @(negedge clk_50);
    chk("hs_ready_ch1_hold", 32'(cfg_ready), 32'h0);
    set_cfg(2, 1, 0, 1'b0);
    chk("hs_ready_ch2", 32'(cfg_ready), 32'h1);
    @(negedge clk_50);
    set_cfg(1, 5, 0, 1'b0);
    for (int k = 4; k <= 9; k++) begin
      @(negedge clk_50);
      chk($sformatf("hs_ready_ch1_pos%0d", k), 32'(cfg_ready), 32'(k == 9));
    end
    @(negedge clk_50);
    cfg_valid = 1'b0;
    chk("hs_ready_ch1_second_pend", 32'(cfg_ready), 32'h0);
    check_period(10, 16'h03C0, 16'h0003, 16'h0001, 16'h0);

    // Write on the wrap cycle; duty == P gives constant high
    check_cycles(10, 0, 8, 16'h03C0, 16'h001F, 16'h0001, 16'h0);
    set_cfg(3, 10, 0, 1'b0);
    chk("wrap_ready_ch3", 32'(cfg_ready), 32'h1);
    check_cycles(10, 8, 2, 16'h03C0, 16'h001F, 16'h0001, 16'h0);
    chk("wrap_ready_ch3_after", 32'(cfg_ready), 32'h1);
    check_period(10, 16'h03C0, 16'h001F, 16'h0001, 16'h03FF);

    // Period change 10 -> 6 mid-period
    check_cycles(10, 0, 3, 16'h03C0, 16'h001F, 16'h0001, 16'h03FF);
    period = W'(6);
    check_cycles(10, 3, 7, 16'h03C0, 16'h001F, 16'h0001, 16'h03FF);
    check_period(6, 16'h003C, 16'h001F, 16'h0001, 16'h003F);

    // period = 1 behaves as P = 2
    period = W'(1);
    check_period(6, 16'h003C, 16'h001F, 16'h0001, 16'h003F);
    check_period(2, 16'h0003, 16'h0003, 16'h0001, 16'h0003);
    check_period(2, 16'h0003, 16'h0003, 16'h0001, 16'h0003);

    // Disable, configure while idle, re-enable
    en = 1'b0;
    period = W'(10);
    @(negedge clk_50);
    chk("dis_pwm", 32'(pwm_out), 32'h0);
    chk("dis_tick", 32'(period_tick), 32'h0);
    set_cfg(1, 3, 2, 1'b0);
    chk("dis_ready", 32'(cfg_ready), 32'h1);
    @(negedge clk_50);
    cfg_valid = 1'b0;
    #1;
    chk("dis_ready_after", 32'(cfg_ready), 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_50);
      chk($sformatf("dis_hold_pwm_%0d", k), 32'(pwm_out), 32'h0);
      chk($sformatf("dis_hold_tick_%0d", k), 32'(period_tick), 32'h0);
    end
    en = 1'b1;
    @(negedge clk_50);
    check_period(10, 16'h03C0, 16'h001C, 16'h0001, 16'h03FF);

    // Asynchronous reset mid-period, then default period
    check_cycles(10, 0, 4, 16'h03C0, 16'h001C, 16'h0001, 16'h03FF);
    chk("pre_rst_pwm", 32'(pwm_out), 32'hA);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", 32'(pwm_out), 32'h0);
    chk("async_rst_tick", 32'(period_tick), 32'h0);
    @(negedge clk_50);
    rst_n = 1'b1;
    @(negedge clk_50);
    chk("post_rst_tick", 32'(period_tick), 32'h1);
    chk("post_rst_pwm", 32'(pwm_out), 32'h0);
    tick_interval("def_period_len", 5000);
    tick_interval("next_period_len", 10);
    chk("post_rst_cfg_cleared", 32'(pwm_out), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
